// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end.
//   Holds the PC, fetches one word at a time from instruction memory over a
//   req/ready handshake and presents it (with valid) to the decoder. When the
//   presented instruction is accepted, the PC advances by 4 or is redirected
//   to branch_target.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr              fetch request and word-aligned address
//   imem_rdata/ready/err       memory response (err qualified by ready)
//   stall                      downstream not accepting the presented instr
//   pc_src, branch_target      redirect, sampled only on the accept cycle
//   instr_valid, instr         presented instruction
//   cond/op/funct/rd/sh        decoder fields sliced from instr
//   pc_out, pc_plus8           address of presented instr and that + 8
//   fault                      sticky fetch-error flag (cleared only by reset)
//   retired_cnt                count of accepted instructions (wraps)
module fetch_unit #(
  parameter int unsigned     ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  input  logic              imem_err,
  input  logic              stall,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd,
  output logic [1:0]        sh,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus8,
  output logic              fault,
  output logic [31:0]       retired_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    FAULT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              fetch_done;
  logic              fetch_err;

  // Handshake qualifiers; memory responses outside FETCH are ignored.
  assign fetch_done = (state == FETCH) && imem_ready && !imem_err;
  assign fetch_err  = (state == FETCH) && imem_ready && imem_err;
  assign accept     = (state == HOLD) && !stall;

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    unique case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (fetch_err)       state_nxt = FAULT;
        else if (fetch_done) state_nxt = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (accept) state_nxt = FETCH;
      end
      FAULT: fault = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_done) instr <= imem_rdata;
      if (accept) begin
        retired_cnt <= retired_cnt + 32'd1;
        if (pc_src) pc <= {branch_target[ADDR_W-1:2], 2'b00};
        else        pc <= pc + ADDR_W'(4);
      end
    end
  end

  // pc only changes on accept, so it doubles as the presented address and
  // stays stable for the whole of an outstanding request.
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign pc_plus8  = pc + ADDR_W'(8);

  assign cond  = instr[31:28];
  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign rd    = instr[15:12];
  assign sh    = instr[6:5];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the fetch/present/accept behaviour.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_err;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [1:0]  sh;
  logic [31:0] pc_out;
  logic [31:0] pc_plus8;
  logic        fault;
  logic [31:0] retired_cnt;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_err(imem_err),
    .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr),
    .cond(cond), .op(op), .funct(funct), .rd(rd), .sh(sh),
    .pc_out(pc_out), .pc_plus8(pc_plus8), .fault(fault), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: transaction view of the front end.
  logic [31:0] m_pc, m_instr, m_retired;
  bit          m_started, m_presenting, m_fault;

  function automatic void model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0;
    m_started = 0; m_presenting = 0; m_fault = 0;
  endfunction

  function automatic void model_step();
    if (m_fault) return;
    if (!m_started) begin
      m_started = 1;
    end else if (!m_presenting) begin
      if (imem_ready) begin
        if (imem_err) m_fault = 1;
        else begin
          m_instr = imem_rdata;
          m_presenting = 1;
        end
      end
    end else if (!stall) begin
      m_pc = pc_src ? (branch_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
      m_presenting = 0;
      m_retired = m_retired + 32'd1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic exp_req;
    exp_req = m_started && !m_presenting && !m_fault;
    chk("req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("addr", imem_addr, m_pc);
    chk("valid", 32'(instr_valid), 32'(m_presenting));
    chk("instr", instr, m_instr);
    chk("cond", 32'(cond), m_instr >> 28);
    chk("op", 32'(op), (m_instr >> 26) & 32'h3);
    chk("funct", 32'(funct), (m_instr >> 20) & 32'h3F);
    chk("rd", 32'(rd), (m_instr >> 12) & 32'hF);
    chk("sh", 32'(sh), (m_instr >> 5) & 32'h3);
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus8", pc_plus8, m_pc + 32'd8);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("retired", retired_cnt, m_retired);
  endtask

  // Called at a negedge with inputs set: check, advance model, move to next negedge.
  task automatic cycle();
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic rdy, input logic err, input logic [31:0] rdat,
                        input logic stl, input logic src, input logic [31:0] tgt);
    imem_ready = rdy; imem_err = err; imem_rdata = rdat;
    stall = stl; pc_src = src; branch_target = tgt;
  endtask

  logic [31:0] a0, s_instr, s_pc, s_ret;
  int          guard;

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 32'h0, 0, 0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_retired", retired_cnt, 32'h0);
    rst_n = 1'b1;

    // 1: zero-wait streaming, sequential addresses
    set_in(1, 0, $urandom, 0, 0, $urandom);
    cycle();                                   // IDLE
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", imem_addr, 32'(4 * i));
      imem_rdata = $urandom;
      cycle();                                 // FETCH
      chk("t1_valid", 32'(instr_valid), 32'h1);
      cycle();                                 // HOLD, accepted
    end
    chk("t1_retired3", retired_cnt, 32'd3);

    // 2: wait states keep req/addr stable
    a0 = imem_addr;
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_req", 32'(imem_req), 32'h1);
      chk("t2_addr_stable", imem_addr, a0);
      chk("t2_valid", 32'(instr_valid), 32'h0);
      cycle();
    end
    set_in(1, 0, 32'hE081_0002, 0, 0, 32'h0);
    cycle();
    chk("t2_valid1", 32'(instr_valid), 32'h1);
    chk("t2_op", 32'(op), 32'h0);
    chk("t2_funct", 32'(funct), 32'h08);
    chk("t2_rd", 32'(rd), 32'h0);
    chk("t2_cond", 32'(cond), 32'hE);

    // 3: stall in HOLD ignores pc_src/branch_target
    s_instr = instr; s_pc = pc_out; s_ret = retired_cnt;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, $urandom, 1, 1'(i % 2 == 0), $urandom);
      cycle();
      chk("t3_instr", instr, s_instr);
      chk("t3_pc", pc_out, s_pc);
      chk("t3_retired", retired_cnt, s_ret);
      chk("t3_noreq", 32'(imem_req), 32'h0);
    end
    set_in(1, 0, $urandom, 0, 0, $urandom);
    cycle();
    chk("t3_next_addr", imem_addr, s_pc + 32'd4);

    // 4: redirect from 0x10 to 0x103 -> 0x100
    chk("t4_addr", imem_addr, 32'h10);
    cycle();
    chk("t4_pc_out", pc_out, 32'h10);
    chk("t4_pc_plus8", pc_plus8, 32'h18);
    set_in(1, 0, $urandom, 0, 1, 32'h0000_0103);
    cycle();
    chk("t4_target", imem_addr, 32'h100);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 2) != 0), 0, $urandom,
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom);
      cycle();
    end

    // 5: memory error is sticky
    guard = 0;
    set_in(0, 0, $urandom, 0, 0, 32'h0);
    while (!(m_started && !m_presenting) && guard < 20) begin
      cycle();
      guard++;
    end
    chk("t5_reach_fetch", 32'(guard < 20), 32'h1);
    set_in(1, 1, $urandom, 0, 0, 32'h0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      chk("t5_fault", 32'(fault), 32'h1);
      chk("t5_noreq", 32'(imem_req), 32'h0);
      chk("t5_novalid", 32'(instr_valid), 32'h0);
      cycle();
    end

    // 6: async reset clears fault, then clears req mid-FETCH
    #2 rst_n = 1'b0;
    #1 chk("t6_fault_async", 32'(fault), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, $urandom, 0, 0, 32'h0);
    cycle();
    chk("t6_req_before", 32'(imem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_async", 32'(imem_req), 32'h0);
    chk("t6_valid_async", 32'(instr_valid), 32'h0);
    chk("t6_fault_low", 32'(fault), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("t6_first_addr", imem_addr, 32'h0);
    chk("t6_req_after", 32'(imem_req), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
